// File: rtl/i2c_cfg_master_pkg.sv
// Shared types, phase constants and pad-drive decode for the I2C configuration write master.
package i2c_cfg_master_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_ACK,
        S_STOP,
        S_DONE
    } state_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam int         NUM_BYTES = 3;
    localparam logic [1:0] LAST_BYTE = 2'(NUM_BYTES - 1);

    typedef struct packed {
        state_t     state;
        logic [1:0] quarter;
        logic [2:0] bit_idx;
        logic [1:0] byte_idx;
        logic [7:0] shift;
        logic       nack;
    } fsm_t;

    localparam fsm_t FSM_IDLE = '{
        state:    S_IDLE,
        quarter:  Q0,
        bit_idx:  3'd7,
        byte_idx: 2'd0,
        shift:    8'h00,
        nack:     1'b0
    };

    typedef struct packed {
        logic scl_low;
        logic sda_low;
    } pads_t;

    // Pad levels for one quarter of a bus phase; SDA only moves under a low SCL except in START/STOP.
    function automatic pads_t pad_drive(input state_t state, input logic [1:0] quarter,
                                        input logic data_bit);
        pads_t p;
        p.scl_low = 1'b0;
        p.sda_low = 1'b0;
        case (state)
            S_START: begin
                p.sda_low = (quarter != Q0);
                p.scl_low = (quarter == Q3);
            end
            S_BIT: begin
                p.scl_low = (quarter == Q0) || (quarter == Q1);
                p.sda_low = ~data_bit;
            end
            S_ACK: begin
                p.scl_low = (quarter == Q0) || (quarter == Q1);
            end
            S_STOP: begin
                p.scl_low = (quarter == Q0);
                p.sda_low = (quarter != Q3);
            end
            default: ;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/i2c_cfg_master_tick_gen.sv
// Free-running prescaler emitting a one-cycle tick every PRESCALE clocks; clearable to realign phase.
module i2c_cfg_master_tick_gen #(
    parameter int PRESCALE = 5000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam int             W    = $clog2(PRESCALE);
    localparam logic [W-1:0]   LAST = W'(PRESCALE - 1);

    logic [W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tick = (r_count == LAST);

endmodule

// File: rtl/i2c_cfg_master.sv
// Write-only I2C master: START, {dev,0}, reg, data, STOP, with open-drain pad enables registered.
module i2c_cfg_master #(
    parameter int PRESCALE      = 5000,
    parameter bit ABORT_ON_NACK = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic [6:0] i_dev_addr,
    input  logic [7:0] i_reg_addr,
    input  logic [7:0] i_reg_data,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_nack,
    input  logic       i_sda_in,
    output logic       o_scl_drv_low,
    output logic       o_sda_drv_low
);

    import i2c_cfg_master_pkg::*;

    fsm_t       r_fsm;
    fsm_t       w_fsm_next;
    logic [7:0] r_reg_addr;
    logic [7:0] r_reg_data;
    logic       w_accept;
    logic       w_qtick;
    pads_t      w_pads;
    logic       w_ready;
    logic       w_busy;
    logic       w_done;
    logic       w_nack;
    logic       r_req_ready;
    logic       r_busy;
    logic       r_done;
    logic       r_nack;
    logic       r_scl_drv_low;
    logic       r_sda_drv_low;

    assign w_accept = i_req_valid & r_req_ready;

    i2c_cfg_master_tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (w_accept),
        .o_tick(w_qtick)
    );

    // Outputs are registered from the next-state decode so the pads never see decode glitches.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fsm         <= FSM_IDLE;
            r_req_ready   <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_nack        <= 1'b0;
            r_scl_drv_low <= 1'b0;
            r_sda_drv_low <= 1'b0;
        end else begin
            r_fsm         <= w_fsm_next;
            r_req_ready   <= w_ready;
            r_busy        <= w_busy;
            r_done        <= w_done;
            r_nack        <= w_nack;
            r_scl_drv_low <= w_pads.scl_low;
            r_sda_drv_low <= w_pads.sda_low;
        end
    end

    // NOTE: payload registers carry no reset; they are only read after an accept has loaded them.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_reg_addr <= i_reg_addr;
            r_reg_data <= i_reg_data;
        end
    end

    always_comb begin
        // NOTE: hold-current default first, so no branch leaves a field unassigned (no latches).
        w_fsm_next = r_fsm;
        case (r_fsm.state)
            S_IDLE: begin
                if (w_accept) begin
                    w_fsm_next          = FSM_IDLE;
                    w_fsm_next.state    = S_START;
                    w_fsm_next.shift    = {i_dev_addr, 1'b0};
                end
            end
            S_START: begin
                if (w_qtick) begin
                    w_fsm_next.quarter = r_fsm.quarter + 2'd1;
                    if (r_fsm.quarter == Q3) begin
                        w_fsm_next.state = S_BIT;
                    end
                end
            end
            S_BIT: begin
                if (w_qtick) begin
                    w_fsm_next.quarter = r_fsm.quarter + 2'd1;
                    if (r_fsm.quarter == Q3) begin
                        if (r_fsm.bit_idx == 3'd0) begin
                            w_fsm_next.state = S_ACK;
                        end else begin
                            w_fsm_next.bit_idx = r_fsm.bit_idx - 3'd1;
                            w_fsm_next.shift   = {r_fsm.shift[6:0], 1'b0};
                        end
                    end
                end
            end
            S_ACK: begin
                if (w_qtick) begin
                    w_fsm_next.quarter = r_fsm.quarter + 2'd1;
                    if (r_fsm.quarter == Q2) begin
                        w_fsm_next.nack = r_fsm.nack | i_sda_in;
                    end
                    if (r_fsm.quarter == Q3) begin
                        if ((ABORT_ON_NACK && r_fsm.nack) || (r_fsm.byte_idx == LAST_BYTE)) begin
                            w_fsm_next.state = S_STOP;
                        end else begin
                            w_fsm_next.state    = S_BIT;
                            w_fsm_next.byte_idx = r_fsm.byte_idx + 2'd1;
                            w_fsm_next.bit_idx  = 3'd7;
                            w_fsm_next.shift    = (r_fsm.byte_idx == 2'd0) ? r_reg_addr : r_reg_data;
                        end
                    end
                end
            end
            S_STOP: begin
                if (w_qtick) begin
                    w_fsm_next.quarter = r_fsm.quarter + 2'd1;
                    if (r_fsm.quarter == Q3) begin
                        w_fsm_next.state = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_fsm_next.state = S_IDLE;
            end
            default: begin
                w_fsm_next = FSM_IDLE;
            end
        endcase
    end

    always_comb begin
        w_pads  = pad_drive(w_fsm_next.state, w_fsm_next.quarter, w_fsm_next.shift[7]);
        w_ready = (w_fsm_next.state == S_IDLE);
        w_busy  = ~w_ready;
        w_done  = (w_fsm_next.state == S_DONE);
        w_nack  = w_done & w_fsm_next.nack;
    end

    assign o_req_ready   = r_req_ready;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_nack        = r_nack;
    assign o_scl_drv_low = r_scl_drv_low;
    assign o_sda_drv_low = r_sda_drv_low;

endmodule

// File: tb/tb_i2c_cfg_master.sv
// Bench for i2c_cfg_master: bus decoder plus ACK/NACK slave model, with a byte and timing scoreboard.
module tb_i2c_cfg_master;

    localparam int PRESCALE  = 4;
    localparam int FULL_LAT  = 116 * PRESCALE + 1;
    localparam int ABORT_LAT = 44 * PRESCALE + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [6:0] dev_addr = '0;
    logic [7:0] reg_addr = '0;
    logic [7:0] reg_data = '0;
    logic       sel = 1'b0;
    logic       mon_clear = 1'b0;
    int         nack_byte = -1;

    logic ready_a, busy_a, done_a, nack_a, scl_a, sda_a;
    logic ready_b, busy_b, done_b, nack_b, scl_b, sda_b;
    logic req_ready, busy, done, nack, scl_drv, sda_drv;
    logic slave_low = 1'b0;
    logic sda_bus;

    always #5 clk = ~clk;

    assign req_ready = sel ? ready_b : ready_a;
    assign busy      = sel ? busy_b  : busy_a;
    assign done      = sel ? done_b  : done_a;
    assign nack      = sel ? nack_b  : nack_a;
    assign scl_drv   = sel ? scl_b   : scl_a;
    assign sda_drv   = sel ? sda_b   : sda_a;
    assign sda_bus   = ~sda_drv & ~slave_low;

    i2c_cfg_master #(.PRESCALE(PRESCALE), .ABORT_ON_NACK(1'b1)) dut_abort (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid & ~sel), .o_req_ready(ready_a),
        .i_dev_addr(dev_addr), .i_reg_addr(reg_addr), .i_reg_data(reg_data),
        .o_busy(busy_a), .o_done(done_a), .o_nack(nack_a), .i_sda_in(sda_bus),
        .o_scl_drv_low(scl_a), .o_sda_drv_low(sda_a)
    );

    i2c_cfg_master #(.PRESCALE(PRESCALE), .ABORT_ON_NACK(1'b0)) dut_full (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid & sel), .o_req_ready(ready_b),
        .i_dev_addr(dev_addr), .i_reg_addr(reg_addr), .i_reg_data(reg_data),
        .o_busy(busy_b), .o_done(done_b), .o_nack(nack_b), .i_sda_in(sda_bus),
        .o_scl_drv_low(scl_b), .o_sda_drv_low(sda_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus decoder and slave: bytes latched on SCL rising, ACK driven from the 8th fall to the 9th fall.
    logic       prev_scl = 1'b1, prev_sda = 1'b1;
    logic       cur_scl, cur_sda;
    logic [7:0] mon_shift = '0;
    int         mon_nbit = 0, mon_byte = 0;
    logic [7:0] obs_mem [0:63];
    int         obs_wr = 0, n_start = 0, n_stop = 0;

    always @(negedge clk) begin
        cur_scl = ~scl_drv;
        cur_sda = ~sda_drv & ~slave_low;
        if (mon_clear) begin
            slave_low = 1'b0;
            mon_nbit  = 0;
            mon_byte  = 0;
        end else if (prev_scl && cur_scl) begin
            if (prev_sda && !cur_sda) begin
                n_start++;
                mon_nbit = 0;
                mon_byte = 0;
            end else if (!prev_sda && cur_sda) begin
                n_stop++;
                mon_nbit = 0;
            end
        end else if (!prev_scl && cur_scl) begin
            if (mon_nbit < 8) begin
                mon_shift = {mon_shift[6:0], cur_sda};
                mon_nbit++;
                if (mon_nbit == 8) begin
                    obs_mem[6'(obs_wr)] = mon_shift;
                    obs_wr++;
                end
            end else begin
                mon_nbit = 9;
            end
        end else if (prev_scl && !cur_scl) begin
            if (mon_nbit == 8) begin
                slave_low = (mon_byte != nack_byte);
            end else if (mon_nbit == 9) begin
                slave_low = 1'b0;
                mon_nbit  = 0;
                mon_byte++;
            end
        end
        prev_scl = cur_scl;
        prev_sda = ~sda_drv & ~slave_low;
    end

    int         errors = 0;
    int         checks = 0;
    int         obs_rd = 0;
    logic [7:0] exp_q[$];

    task automatic push_exp(input logic [6:0] d, input logic [7:0] r, input logic [7:0] v,
                            input int nbytes);
        exp_q.push_back({d, 1'b0});
        if (nbytes > 1) exp_q.push_back(r);
        if (nbytes > 2) exp_q.push_back(v);
    endtask

    task automatic start_req(input logic [6:0] d, input logic [7:0] r, input logic [7:0] v,
                             input bit hold, output int t_acc, output bit ok);
        @(negedge clk);
        dev_addr  = d;
        reg_addr  = r;
        reg_data  = v;
        req_valid = 1'b1;
        ok    = 1'b0;
        t_acc = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            if (i > 0) @(negedge clk);
            if (req_ready) begin
                ok    = 1'b1;
                t_acc = cyc;
            end
        end
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
        dev_addr = 7'($urandom);
        reg_addr = 8'($urandom);
        reg_data = 8'($urandom);
    endtask

    task automatic wait_done(input int budget, output int t_done, output logic nk,
                             output bit ok, output bit busy_ok);
        ok      = 1'b0;
        t_done  = 0;
        nk      = 1'b0;
        busy_ok = 1'b1;
        for (int i = 0; i < budget && !ok; i++) begin
            if (!busy || req_ready) busy_ok = 1'b0;
            if (done) begin
                ok     = 1'b1;
                t_done = cyc;
                nk     = nack;
            end
            if (!ok) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int dones;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst   = 1'b0;
        dones = 0;
        repeat (100) begin
            @(negedge clk);
            if (done) dones++;
        end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", req_ready); end
        checks++; if (scl_drv !== 1'b0) begin errors++; $display("FAIL reset_scl got=%b want=0", scl_drv); end
        checks++; if (sda_drv !== 1'b0) begin errors++; $display("FAIL reset_sda got=%b want=0", sda_drv); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (nack !== 1'b0) begin errors++; $display("FAIL reset_nack got=%b want=0", nack); end
        checks++; if (dones != 0) begin errors++; $display("FAIL reset_done got=%0d want=0", dones); end
    endtask

    task automatic test_write_ack();
        int t_acc, t_done, s0, p0;
        logic nk;
        bit ok, bok;
        logic [7:0] eb;
        sel = 1'b0; nack_byte = -1;
        s0 = n_start; p0 = n_stop;
        push_exp(7'h39, 8'h41, 8'h10, 3);
        start_req(7'h39, 8'h41, 8'h10, 1'b0, t_acc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ack_accept timeout"); end
        checks++; if (busy !== 1'b1 || req_ready !== 1'b0) begin
            errors++; $display("FAIL ack_busy_after_accept busy=%b ready=%b want 1/0", busy, req_ready); end
        wait_done(2000, t_done, nk, ok, bok);
        checks++; if (!ok) begin errors++; $display("FAIL ack_done timeout"); end
        checks++; if (t_done - t_acc != FULL_LAT) begin
            errors++; $display("FAIL ack_latency got=%0d want=%0d", t_done - t_acc, FULL_LAT); end
        checks++; if (nk !== 1'b0) begin errors++; $display("FAIL ack_nack got=%b want=0", nk); end
        checks++; if (!bok) begin errors++; $display("FAIL ack_busy_window busy/ready wrong before done"); end
        while (exp_q.size() > 0) begin
            eb = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_wr) begin errors++; $display("FAIL ack_byte missing want=0x%02h", eb); end
            else begin
                if (obs_mem[6'(obs_rd)] !== eb) begin
                    errors++; $display("FAIL ack_byte got=0x%02h want=0x%02h", obs_mem[6'(obs_rd)], eb); end
                obs_rd++;
            end
        end
        checks++; if (obs_wr != obs_rd) begin errors++; $display("FAIL ack_extra_bytes got=%0d want=0", obs_wr - obs_rd); end
        checks++; if (n_start - s0 != 1 || n_stop - p0 != 1) begin
            errors++; $display("FAIL ack_start_stop got=%0d/%0d want=1/1", n_start - s0, n_stop - p0); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || scl_drv !== 1'b0 || sda_drv !== 1'b0) begin
            errors++; $display("FAIL ack_after_done done=%b busy=%b ready=%b scl=%b sda=%b want 0/0/1/0/0",
                               done, busy, req_ready, scl_drv, sda_drv); end
    endtask

    task automatic test_nack_abort();
        int t_acc, t_done, p0;
        logic nk;
        bit ok, bok;
        logic [7:0] eb;
        sel = 1'b0; nack_byte = 0;
        p0 = n_stop;
        push_exp(7'h50, 8'h9C, 8'h3E, 1);
        start_req(7'h50, 8'h9C, 8'h3E, 1'b0, t_acc, ok);
        wait_done(2000, t_done, nk, ok, bok);
        checks++; if (!ok) begin errors++; $display("FAIL abort_done timeout"); end
        checks++; if (t_done - t_acc != ABORT_LAT) begin
            errors++; $display("FAIL abort_latency got=%0d want=%0d", t_done - t_acc, ABORT_LAT); end
        checks++; if (nk !== 1'b1) begin errors++; $display("FAIL abort_nack got=%b want=1", nk); end
        while (exp_q.size() > 0) begin
            eb = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_wr) begin errors++; $display("FAIL abort_byte missing want=0x%02h", eb); end
            else begin
                if (obs_mem[6'(obs_rd)] !== eb) begin
                    errors++; $display("FAIL abort_byte got=0x%02h want=0x%02h", obs_mem[6'(obs_rd)], eb); end
                obs_rd++;
            end
        end
        checks++; if (obs_wr != obs_rd) begin errors++; $display("FAIL abort_extra_bytes got=%0d want=0", obs_wr - obs_rd); end
        checks++; if (n_stop - p0 != 1) begin errors++; $display("FAIL abort_stop got=%0d want=1", n_stop - p0); end
        nack_byte = -1;
    endtask

    task automatic test_nack_no_abort();
        int t_acc, t_done;
        logic nk;
        bit ok, bok;
        logic [7:0] eb;
        sel = 1'b1; nack_byte = 0;
        push_exp(7'h2A, 8'hC3, 8'h5A, 3);
        start_req(7'h2A, 8'hC3, 8'h5A, 1'b0, t_acc, ok);
        wait_done(2000, t_done, nk, ok, bok);
        checks++; if (!ok) begin errors++; $display("FAIL noabort_done timeout"); end
        checks++; if (t_done - t_acc != FULL_LAT) begin
            errors++; $display("FAIL noabort_latency got=%0d want=%0d", t_done - t_acc, FULL_LAT); end
        checks++; if (nk !== 1'b1) begin errors++; $display("FAIL noabort_nack got=%b want=1", nk); end
        while (exp_q.size() > 0) begin
            eb = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_wr) begin errors++; $display("FAIL noabort_byte missing want=0x%02h", eb); end
            else begin
                if (obs_mem[6'(obs_rd)] !== eb) begin
                    errors++; $display("FAIL noabort_byte got=0x%02h want=0x%02h", obs_mem[6'(obs_rd)], eb); end
                obs_rd++;
            end
        end
        checks++; if (obs_wr != obs_rd) begin errors++; $display("FAIL noabort_extra_bytes got=%0d want=0", obs_wr - obs_rd); end
        @(negedge clk);
        sel = 1'b0; nack_byte = -1;
    endtask

    task automatic test_busy_ignore();
        int t_acc, t_done, busy_seen;
        logic nk;
        bit ok, bok;
        logic [7:0] eb;
        push_exp(7'h1D, 8'h07, 8'hE4, 3);
        start_req(7'h1D, 8'h07, 8'hE4, 1'b0, t_acc, ok);
        repeat (100) @(negedge clk);
        req_valid = 1'b1; dev_addr = 7'h11; reg_addr = 8'h22; reg_data = 8'h33;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL ignore_ready got=%b want=0", req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        wait_done(2000, t_done, nk, ok, bok);
        checks++; if (t_done - t_acc != FULL_LAT) begin
            errors++; $display("FAIL ignore_latency got=%0d want=%0d", t_done - t_acc, FULL_LAT); end
        while (exp_q.size() > 0) begin
            eb = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_wr) begin errors++; $display("FAIL ignore_byte missing want=0x%02h", eb); end
            else begin
                if (obs_mem[6'(obs_rd)] !== eb) begin
                    errors++; $display("FAIL ignore_byte got=0x%02h want=0x%02h", obs_mem[6'(obs_rd)], eb); end
                obs_rd++;
            end
        end
        busy_seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
        checks++; if (busy_seen != 0 || obs_wr != obs_rd) begin
            errors++; $display("FAIL ignore_no_second busy_cycles=%0d extra_bytes=%0d want 0/0", busy_seen, obs_wr - obs_rd); end
    endtask

    task automatic test_back_to_back();
        int t_acc, t_done, t_acc2, t_done2;
        logic nk;
        bit ok, bok, got;
        logic [7:0] eb;
        push_exp(7'h39, 8'hA5, 8'h0F, 3);
        start_req(7'h39, 8'hA5, 8'h0F, 1'b1, t_acc, ok);
        dev_addr = 7'h4C; reg_addr = 8'h81; reg_data = 8'hFF;
        push_exp(7'h4C, 8'h81, 8'hFF, 3);
        wait_done(2000, t_done, nk, ok, bok);
        got = 1'b0; t_acc2 = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (req_ready && req_valid) begin got = 1'b1; t_acc2 = cyc; end
        end
        checks++; if (!got || t_acc2 - t_done != 1) begin
            errors++; $display("FAIL b2b_reaccept got=%0d want=1 (seen=%b)", t_acc2 - t_done, got); end
        @(negedge clk);
        req_valid = 1'b0;
        wait_done(2000, t_done2, nk, ok, bok);
        checks++; if (t_done2 - t_acc2 != FULL_LAT || !ok) begin
            errors++; $display("FAIL b2b_latency got=%0d want=%0d", t_done2 - t_acc2, FULL_LAT); end
        while (exp_q.size() > 0) begin
            eb = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_wr) begin errors++; $display("FAIL b2b_byte missing want=0x%02h", eb); end
            else begin
                if (obs_mem[6'(obs_rd)] !== eb) begin
                    errors++; $display("FAIL b2b_byte got=0x%02h want=0x%02h", obs_mem[6'(obs_rd)], eb); end
                obs_rd++;
            end
        end
    endtask

    task automatic test_rst_mid();
        int t_acc, t_done, dones;
        logic nk;
        bit ok, bok;
        logic [7:0] eb;
        start_req(7'h39, 8'h41, 8'h10, 1'b0, t_acc, ok);
        for (int i = 0; i < 1000 && cyc < t_acc + 50 * PRESCALE; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (scl_drv !== 1'b0 || sda_drv !== 1'b0) begin
            errors++; $display("FAIL rst_lines scl=%b sda=%b want 0/0", scl_drv, sda_drv); end
        checks++; if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL rst_state ready=%b busy=%b done=%b want 1/0/0", req_ready, busy, done); end
        rst = 1'b0;
        mon_clear = 1'b1;
        dones = 0;
        repeat (600) begin
            @(negedge clk);
            mon_clear = 1'b0;
            if (done) dones++;
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL rst_no_done got=%0d want=0", dones); end
        obs_rd = obs_wr;
        push_exp(7'h62, 8'h3C, 8'hB7, 3);
        start_req(7'h62, 8'h3C, 8'hB7, 1'b0, t_acc, ok);
        wait_done(2000, t_done, nk, ok, bok);
        checks++; if (!ok || t_done - t_acc != FULL_LAT || nk !== 1'b0) begin
            errors++; $display("FAIL rst_recover latency=%0d nack=%b want %0d/0", t_done - t_acc, nk, FULL_LAT); end
        while (exp_q.size() > 0) begin
            eb = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_wr) begin errors++; $display("FAIL rst_byte missing want=0x%02h", eb); end
            else begin
                if (obs_mem[6'(obs_rd)] !== eb) begin
                    errors++; $display("FAIL rst_byte got=0x%02h want=0x%02h", obs_mem[6'(obs_rd)], eb); end
                obs_rd++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_ack();
        test_nack_abort();
        test_nack_no_abort();
        test_busy_ignore();
        test_back_to_back();
        test_rst_mid();
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
